// File: rtl/tdm_pkg.sv
// Shared definitions for both ends of the 4-channel time-division link.
package tdm_pkg;

  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned WIDTH_DEF = 1;
  localparam int unsigned SLOT_W    = $clog2(NCH_DEF);

  typedef enum logic [0:0] {
    HUNT,
    LOCKED
  } tdm_rx_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Mod-NCH slot counter with synchronous clear-to-0, load-to-1 and increment.
module tdm_slot_ctr #(
  parameter  int unsigned NCH = 4,
  localparam int unsigned SW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load1_i,
  input  logic          inc_i,
  output logic [SW-1:0] cnt_o
);

  logic [SW-1:0] cnt_q, cnt_d;

  // NCH is a power of two, so the natural SW-bit wrap gives mod NCH.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = SW'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_rx_demux.sv
// TDM receiver: locks to frame sync and reassembles NCH slot samples into one
// registered parallel frame.
module tdm_rx_demux
  import tdm_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned NCH   = NCH_DEF,
  localparam int unsigned SlotW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 valid_in,
  input  logic                 sync,
  output logic [NCH*WIDTH-1:0] dout,
  output logic                 frame_valid,
  output logic [SlotW-1:0]     slot,
  output logic                 locked,
  output logic                 sync_err
);

  localparam logic [SlotW-1:0] LastSlot = SlotW'(NCH - 1);

  tdm_rx_state_t state_q, state_d;

  logic [NCH-1:0][WIDTH-1:0] shadow_q;
  logic [NCH-1:0][WIDTH-1:0] dout_q;
  logic [NCH-1:0][WIDTH-1:0] frame_d;
  logic                      frame_valid_q;
  logic                      sync_err_q;

  logic [SlotW-1:0] slot_cnt;
  logic [SlotW-1:0] wr_idx;
  logic             shadow_wr;
  logic             ctr_clr;
  logic             ctr_load1;
  logic             ctr_inc;
  logic             frame_done;
  logic             err;

  always_comb begin
    state_d    = state_q;
    shadow_wr  = 1'b0;
    ctr_clr    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_inc    = 1'b0;
    frame_done = 1'b0;
    err        = 1'b0;
    if (valid_in) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_wr = 1'b1;
            ctr_load1 = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Sync always restarts at slot 0; mid-frame it abandons the partial frame.
            shadow_wr = 1'b1;
            ctr_load1 = 1'b1;
            err       = (slot_cnt != '0);
          end else if (slot_cnt == '0) begin
            err     = 1'b1;
            ctr_clr = 1'b1;
            state_d = HUNT;
          end else begin
            shadow_wr  = 1'b1;
            ctr_inc    = 1'b1;
            frame_done = (slot_cnt == LastSlot);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign wr_idx = sync ? '0 : slot_cnt;

  always_comb begin
    frame_d          = shadow_q;
    frame_d[NCH - 1] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (shadow_wr) begin
        shadow_q[wr_idx] <= din;
      end
      if (frame_done) begin
        dout_q <= frame_d;
      end
      frame_valid_q <= frame_done;
      sync_err_q    <= err;
    end
  end

  tdm_slot_ctr #(
    .NCH (NCH)
  ) u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (ctr_clr),
    .load1_i (ctr_load1),
    .inc_i   (ctr_inc),
    .cnt_o   (slot_cnt)
  );

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign slot        = slot_cnt;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_rx_demux.sv
// Scoreboard bench for tdm_rx_demux: stimulus queues expected frames and error
// beats, a negedge monitor pops and compares whenever the DUT pulses.
module tb_tdm_rx_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din;
  logic       valid_in;
  logic       sync;
  logic [3:0] dout;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int checks   = 0;
  int failures = 0;
  int beat_no  = 0;

  logic [3:0] exp_q[$];
  int         err_q[$];
  logic [3:0] last_dout = '0;

  tdm_rx_demux #(
    .WIDTH (1),
    .NCH   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .valid_in    (valid_in),
    .sync        (sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one beat for one cycle; returns 1 time unit after the sampling edge.
  task automatic beat(input logic s, input logic d);
    valid_in = 1'b1;
    sync     = s;
    din      = d;
    @(posedge clk);
    #1;
    beat_no++;
    valid_in = 1'b0;
    sync     = 1'b0;
    din      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_state(input string name, input logic lk, input logic [1:0] sl);
    chk({name, "_locked"}, locked, lk);
    chk({name, "_slot"}, slot, sl);
  endtask

  // Monitor: compares dout/pulses against the scoreboard on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_dout = '0;
      end else begin
        if (frame_valid || sync_err) begin
          chk("pulse_overlap", frame_valid & sync_err, 1'b0);
        end
        if (frame_valid) begin
          chk("frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            last_dout = exp_q.pop_front();
            chk("frame_dout", dout, last_dout);
          end
        end else begin
          chk("dout_hold", dout, last_dout);
        end
        if (sync_err) begin
          chk("sync_err_expected", err_q.size() != 0, 1'b1);
          if (err_q.size() != 0) begin
            chk("sync_err_beat", beat_no, err_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sync     = 1'b0;
    din      = 1'b0;

    // Reset then idle
    idle(3);
    chk("rst_dout", dout, 4'b0000);
    chk_state("rst", 1'b0, 2'd0);
    rst_n = 1'b1;
    idle(10);
    chk("idle_dout", dout, 4'b0000);
    chk_state("idle", 1'b0, 2'd0);

    // Clean back-to-back frames
    beat(1'b1, 1'b1);
    chk_state("clean_b1", 1'b1, 2'd1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    exp_q.push_back(4'b1101);
    beat(1'b0, 1'b1);
    chk_state("clean_b4", 1'b1, 2'd0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    exp_q.push_back(4'b0110);
    beat(1'b0, 1'b0);
    idle(3);
    chk("clean_hold", dout, 4'b0110);

    // Gapped frame: slot only moves on beats
    beat(1'b1, 1'b1);
    idle(2);
    chk_state("gap_b1", 1'b1, 2'd1);
    beat(1'b0, 1'b0);
    idle(2);
    chk_state("gap_b2", 1'b1, 2'd2);
    beat(1'b0, 1'b1);
    idle(2);
    chk_state("gap_b3", 1'b1, 2'd3);
    exp_q.push_back(4'b1101);
    beat(1'b0, 1'b1);
    idle(2);
    chk_state("gap_b4", 1'b1, 2'd0);

    // Early sync at slot 2 restarts the frame
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    err_q.push_back(beat_no + 1);
    beat(1'b1, 1'b0);
    chk_state("early", 1'b1, 2'd1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk("early_partial", dout, 4'b1101);
    exp_q.push_back(4'b1110);
    beat(1'b0, 1'b1);
    idle(2);

    // Missing sync drops lock; relock on next sync
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    exp_q.push_back(4'b0100);
    beat(1'b0, 1'b0);
    err_q.push_back(beat_no + 1);
    beat(1'b0, 1'b1);
    chk_state("miss", 1'b0, 2'd0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk_state("miss_ignored", 1'b0, 2'd0);
    beat(1'b1, 1'b1);
    chk_state("relock", 1'b1, 2'd1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    exp_q.push_back(4'b0011);
    beat(1'b0, 1'b0);
    idle(2);

    // Reset mid-frame clears outputs without waiting for a clock edge
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", dout, 4'b0000);
    chk_state("midrst", 1'b0, 2'd0);
    chk("midrst_fv", frame_valid, 1'b0);
    chk("midrst_err", sync_err, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    exp_q.push_back(4'b1010);
    beat(1'b0, 1'b1);
    idle(4);

    chk("frames_left", exp_q.size(), 0);
    chk("errs_left", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
